// File: rtl/tile_loader.sv
// tile_loader: responder side of the tile_compute loader handshake.
//
// For each K-segment it reads A rows (m) and B rows (k) from the operand
// buffers, zero-pads them with the latched k/m/n masks, writes TILE_SIZE full
// rows into the PE-array staging registers and then pulses ld_done.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   tile_start                new tile: clears seg_idx, aborts any fill in progress
//   a_base, b_base            operand buffer base word addresses for this tile
//   m_eff, n_eff, k_eff       valid A rows / B columns / K in this segment
//   load_req, ld_done         level request in, single-cycle completion pulse out
//   a_rd_*, b_rd_*            operand buffer read ports (1-cycle read latency)
//   a_wr_*, b_wr_*            staging register row write ports
//   busy, seg_idx             activity flag, completed-segment count in this tile
module tile_loader #(
  parameter int unsigned TILE_SIZE = 8,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned ADDR_BITS = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tile_start,
  input  logic [ADDR_BITS-1:0]           a_base,
  input  logic [ADDR_BITS-1:0]           b_base,
  input  logic [3:0]                     m_eff,
  input  logic [3:0]                     n_eff,
  input  logic                           load_req,
  input  logic [3:0]                     k_eff,
  output logic                           ld_done,
  output logic                           a_rd_en,
  output logic [ADDR_BITS-1:0]           a_rd_addr,
  input  logic [TILE_SIZE*DATA_BITS-1:0] a_rd_data,
  output logic                           b_rd_en,
  output logic [ADDR_BITS-1:0]           b_rd_addr,
  input  logic [TILE_SIZE*DATA_BITS-1:0] b_rd_data,
  output logic                           a_wr_en,
  output logic [$clog2(TILE_SIZE)-1:0]   a_wr_row,
  output logic [TILE_SIZE*DATA_BITS-1:0] a_wr_data,
  output logic                           b_wr_en,
  output logic [$clog2(TILE_SIZE)-1:0]   b_wr_row,
  output logic [TILE_SIZE*DATA_BITS-1:0] b_wr_data,
  output logic                           busy,
  output logic [7:0]                     seg_idx
);

  localparam int unsigned RowW = $clog2(TILE_SIZE);

  typedef enum logic [1:0] {StIdle, StFill, StFlush, StDone} state_e;

  state_e            state_q, state_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [3:0]        ke_q, ke_d, me_q, me_d, ne_q, ne_d;
  logic [7:0]        seg_q, seg_d;
  // Write stage runs one cycle behind issue to line up with the buffer read latency.
  logic              wr_vld_q, wr_vld_d;
  logic [RowW-1:0]   wr_row_q, wr_row_d;
  logic [ADDR_BITS-1:0] row_off;

  function automatic logic [3:0] clamp_t(input logic [3:0] v);
    return (32'(v) > TILE_SIZE) ? 4'(TILE_SIZE) : v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      row_q    <= '0;
      ke_q     <= '0;
      me_q     <= '0;
      ne_q     <= '0;
      seg_q    <= '0;
      wr_vld_q <= 1'b0;
      wr_row_q <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      ke_q     <= ke_d;
      me_q     <= me_d;
      ne_q     <= ne_d;
      seg_q    <= seg_d;
      wr_vld_q <= wr_vld_d;
      wr_row_q <= wr_row_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    ke_d     = ke_q;
    me_d     = me_q;
    ne_d     = ne_q;
    seg_d    = seg_q;
    wr_vld_d = 1'b0;
    wr_row_d = row_q;
    unique case (state_q)
      StIdle: begin
        if (load_req) begin
          ke_d    = clamp_t(k_eff);
          me_d    = clamp_t(m_eff);
          ne_d    = clamp_t(n_eff);
          row_d   = '0;
          state_d = StFill;
        end
      end
      StFill: begin
        wr_vld_d = 1'b1;
        if (row_q == RowW'(TILE_SIZE - 1)) begin
          state_d = StFlush;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      StFlush: state_d = StDone;
      StDone: begin
        state_d = StIdle;
        if (seg_q != 8'hFF) begin
          seg_d = seg_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    // tile_start overrides everything: a same-cycle request in IDLE is taken next cycle.
    if (tile_start) begin
      state_d  = StIdle;
      seg_d    = '0;
      wr_vld_d = 1'b0;
    end
  end

  assign row_off = ADDR_BITS'(32'(seg_q) * TILE_SIZE) + ADDR_BITS'(row_q);

  always_comb begin
    // With ke=0 every A element is masked, so no A reads are needed either.
    a_rd_en   = (state_q == StFill) && (4'(row_q) < me_q) && (ke_q != 4'd0);
    b_rd_en   = (state_q == StFill) && (4'(row_q) < ke_q);
    a_rd_addr = a_rd_en ? a_base + row_off : '0;
    b_rd_addr = b_rd_en ? b_base + row_off : '0;
  end

  always_comb begin
    a_wr_data = '0;
    b_wr_data = '0;
    for (int j = 0; j < int'(TILE_SIZE); j++) begin
      if (wr_vld_q && (4'(wr_row_q) < me_q) && (j < int'(ke_q))) begin
        a_wr_data[j*DATA_BITS +: DATA_BITS] = a_rd_data[j*DATA_BITS +: DATA_BITS];
      end
      if (wr_vld_q && (4'(wr_row_q) < ke_q) && (j < int'(ne_q))) begin
        b_wr_data[j*DATA_BITS +: DATA_BITS] = b_rd_data[j*DATA_BITS +: DATA_BITS];
      end
    end
  end

  assign a_wr_en  = wr_vld_q;
  assign b_wr_en  = wr_vld_q;
  assign a_wr_row = wr_row_q;
  assign b_wr_row = wr_row_q;
  assign ld_done  = (state_q == StDone) && !tile_start;
  assign busy     = (state_q != StIdle);
  assign seg_idx  = seg_q;

endmodule

// File: tb/tb_tile_loader.sv
module tb_tile_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        tile_start;
  logic [11:0] a_base, b_base;
  logic [3:0]  m_eff, n_eff, k_eff;
  logic        load_req;
  logic        ld_done;
  logic        a_rd_en, b_rd_en;
  logic [11:0] a_rd_addr, b_rd_addr;
  logic [63:0] a_rd_data = '0;
  logic [63:0] b_rd_data = '0;
  logic        a_wr_en, b_wr_en;
  logic [2:0]  a_wr_row, b_wr_row;
  logic [63:0] a_wr_data, b_wr_data;
  logic        busy;
  logic [7:0]  seg_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tile_loader #(.TILE_SIZE(8), .DATA_BITS(8), .ADDR_BITS(12)) dut (
    .clk(clk), .rst(rst), .tile_start(tile_start), .a_base(a_base), .b_base(b_base),
    .m_eff(m_eff), .n_eff(n_eff), .load_req(load_req), .k_eff(k_eff), .ld_done(ld_done),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .a_wr_en(a_wr_en), .a_wr_row(a_wr_row), .a_wr_data(a_wr_data),
    .b_wr_en(b_wr_en), .b_wr_row(b_wr_row), .b_wr_data(b_wr_data),
    .busy(busy), .seg_idx(seg_idx)
  );

  // Operand buffer contents: every element odd, so nonzero and distinguishable from padding.
  function automatic logic [63:0] mem_word(input logic [11:0] addr, input logic [7:0] salt);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[j*8 +: 8] = ((addr[7:0] + 8'(j * 16)) ^ salt) | 8'h01;
    return w;
  endfunction

  // Unread cycles return junk so missing row masks show up as nonzero padding.
  always @(posedge clk) begin
    a_rd_data <= a_rd_en ? mem_word(a_rd_addr, 8'h00) : 64'hA5A5_A5A5_A5A5_A5A5;
    b_rd_data <= b_rd_en ? mem_word(b_rd_addr, 8'h5A) : 64'h3C3C_3C3C_3C3C_3C3C;
  end

  function automatic logic [63:0] exp_row(input logic [11:0] addr, input logic [7:0] salt,
                                          input int r, input int rows, input int cols);
    logic [63:0] w;
    if (r >= rows) return 64'h0;
    w = mem_word(addr, salt);
    for (int j = 0; j < 8; j++) if (j >= cols) w[j*8 +: 8] = 8'h00;
    return w;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one segment starting at a negedge; returns at the negedge one cycle after ld_done.
  task automatic run_seg(input string tag, input logic [11:0] ab, input logic [11:0] bb,
                         input int k, input int m, input int n, input int seg, input bit keep,
                         input int exp_na, input int exp_nb, input int exp_seg);
    logic [63:0] aimg[8];
    logic [63:0] bimg[8];
    int lat = -1;
    int na = 0, nb = 0, awr = 0, bwr = 0, aerr = 0, berr = 0, roerr = 0;
    int first = -1, last = -1;
    int ke, me, ne;
    ke = (k > 8) ? 8 : k;
    me = (m > 8) ? 8 : m;
    ne = (n > 8) ? 8 : n;
    for (int i = 0; i < 8; i++) begin
      aimg[i] = 64'hDEAD_BEEF_DEAD_BEEF;
      bimg[i] = 64'hDEAD_BEEF_DEAD_BEEF;
    end
    a_base = ab; b_base = bb;
    k_eff = 4'(k); m_eff = 4'(m); n_eff = 4'(n);
    load_req = 1'b1;
    for (int cyc = 1; cyc <= 20 && lat < 0; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (a_rd_en) begin
        na++;
        if (a_rd_addr !== 12'(ab + seg * 8 + cyc - 1)) aerr++;
      end
      if (b_rd_en) begin
        nb++;
        if (b_rd_addr !== 12'(bb + seg * 8 + cyc - 1)) berr++;
      end
      if (a_wr_en) begin
        awr++;
        aimg[a_wr_row] = a_wr_data;
        if (int'(a_wr_row) != cyc - 2) roerr++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (b_wr_en) begin
        bwr++;
        bimg[b_wr_row] = b_wr_data;
        if (int'(b_wr_row) != cyc - 2) roerr++;
      end
      if (ld_done) lat = cyc;
    end
    check({tag, " ld_done_latency"}, 64'(lat), 64'd10);
    check({tag, " a_reads"}, 64'(na), 64'(exp_na));
    check({tag, " b_reads"}, 64'(nb), 64'(exp_nb));
    check({tag, " a_rd_addr_errs"}, 64'(aerr), 64'd0);
    check({tag, " b_rd_addr_errs"}, 64'(berr), 64'd0);
    check({tag, " wr_row_errs"}, 64'(roerr), 64'd0);
    check({tag, " wr_counts"}, {32'(awr), 32'(bwr)}, {32'd8, 32'd8});
    check({tag, " first_last_wr"}, {32'(first), 32'(last)}, {32'd2, 32'd9});
    for (int r = 0; r < 8; r++) begin
      check($sformatf("%s a_row%0d", tag, r), aimg[r],
            exp_row(12'(ab + seg * 8 + r), 8'h00, r, me, ke));
      check($sformatf("%s b_row%0d", tag, r), bimg[r],
            exp_row(12'(bb + seg * 8 + r), 8'h5A, r, ke, ne));
    end
    if (!keep) load_req = 1'b0;
    @(posedge clk); @(negedge clk);
    check({tag, " ld_done_single"}, 64'(ld_done), 64'd0);
    check({tag, " seg_idx"}, 64'(seg_idx), 64'(exp_seg));
  endtask

  typedef struct {
    logic [11:0] ab;
    logic [11:0] bb;
    int          k, m, n;
    bit          ts;
    bit          keep;
    int          seg_after, na, nb;
  } vec_t;

  vec_t vecs[9];
  int   ld_cnt;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //         ab      bb      k   m   n  ts keep seg na nb
    vecs[0] = '{12'h100, 12'h200,  8,  8, 8, 1, 0, 1, 8, 8};
    vecs[1] = '{12'h100, 12'h200,  3,  5, 2, 1, 0, 1, 5, 3};
    vecs[2] = '{12'h300, 12'h400,  8,  6, 7, 1, 0, 1, 6, 8};
    vecs[3] = '{12'h300, 12'h400,  8,  6, 7, 0, 0, 2, 6, 8};
    vecs[4] = '{12'h300, 12'h400,  4,  6, 7, 0, 0, 3, 6, 4};
    vecs[5] = '{12'hFFC, 12'h010,  8,  8, 8, 1, 0, 1, 8, 8};
    vecs[6] = '{12'h0F0, 12'h0E0,  0,  8, 8, 1, 0, 1, 0, 0};
    vecs[7] = '{12'h0F0, 12'h0E0, 15, 12, 9, 0, 1, 2, 8, 8};
    vecs[8] = '{12'h0F0, 12'h0E0,  2,  1, 8, 0, 0, 3, 1, 2};

    rst = 1'b1; tile_start = 1'b0; load_req = 1'b0;
    a_base = '0; b_base = '0; k_eff = '0; m_eff = '0; n_eff = '0;
    @(negedge clk);
    check("reset ctrl", {ld_done, a_rd_en, b_rd_en, a_wr_en, b_wr_en, busy, seg_idx,
                         a_rd_addr, b_rd_addr, a_wr_row, b_wr_row}, 64'h0);
    check("reset data", a_wr_data | b_wr_data, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      if (vecs[v].ts) begin
        tile_start = 1'b1;
        @(posedge clk); @(negedge clk);
        tile_start = 1'b0;
        check($sformatf("vec%0d seg_idx after tile_start", v), 64'(seg_idx), 64'd0);
      end
      run_seg($sformatf("vec%0d", v), vecs[v].ab, vecs[v].bb, vecs[v].k, vecs[v].m,
              vecs[v].n, vecs[v].seg_after - 1, vecs[v].keep, vecs[v].na, vecs[v].nb,
              vecs[v].seg_after);
    end

    // Abort with tile_start at FILL row 4 (seg_idx is 3 here).
    a_base = 12'h500; b_base = 12'h600; k_eff = 4'd8; m_eff = 4'd8; n_eff = 4'd8;
    load_req = 1'b1;
    repeat (5) begin @(posedge clk); @(negedge clk); end
    check("abort row4 a_rd_addr", 64'(a_rd_addr), 64'h51C);
    tile_start = 1'b1; load_req = 1'b0;
    @(posedge clk); @(negedge clk);
    tile_start = 1'b0;
    check("abort strobes", {a_rd_en, b_rd_en, a_wr_en, b_wr_en, ld_done, busy}, 64'h0);
    check("abort seg_idx", 64'(seg_idx), 64'd0);
    ld_cnt = 0;
    repeat (12) begin @(posedge clk); @(negedge clk); if (ld_done) ld_cnt++; end
    check("abort no ld_done", 64'(ld_cnt), 64'd0);
    run_seg("after_abort", 12'h500, 12'h600, 8, 8, 8, 0, 0, 8, 8, 1);

    // Asynchronous reset mid-fill: outputs drop before any clock edge.
    load_req = 1'b1;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    #2 rst = 1'b1;
    #1;
    check("rst mid-fill outputs", {ld_done, a_rd_en, b_rd_en, a_wr_en, b_wr_en, busy,
                                   seg_idx, a_rd_addr, b_rd_addr}, 64'h0);
    load_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_seg("after_rst", 12'h100, 12'h200, 8, 8, 8, 0, 0, 8, 8, 1);

    // tile_start and load_req together in IDLE: tile_start wins, request taken next cycle.
    tile_start = 1'b1; load_req = 1'b1;
    @(posedge clk); @(negedge clk);
    tile_start = 1'b0;
    check("ts+req same cycle", {busy, seg_idx}, 64'h0);
    run_seg("ts_then_req", 12'h700, 12'h7F0, 8, 8, 8, 0, 0, 8, 8, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
